alu_req_arbiter: RTL
====================

# alu_req_arbiter

Registered 8-way round-robin arbiter that shares the single ALU datapath among up to eight requesters. It selects one requester at a time, drives a 3-bit grant index and its one-hot 3-to-8 decoded grant vector, and enforces a maximum hold time. It sits between the requester front-ends and the ALU operand/opcode muxes, whose select lines are driven by `gnt_idx`.

## Interface

- `HOLD_MAX`, default 15: maximum consecutive cycles one grant may be held. Legal range is 1..255.

- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `req`, input, 8: `req[k]` high means requester k wants, or is still using, the ALU.
- `gnt`, output, 8: one-hot grant, `gnt[k] = gnt_valid & (gnt_idx == k)`. It is all zero when `gnt_valid` is 0.
- `gnt_idx`, output, 3: index of the current or most recent grantee. Drives the ALU source muxes.
- `gnt_valid`, output, 1: high while a grant is active.
- `timeout`, output, 1: one-cycle pulse marking a grant that was removed by the hold limit.

## Operation

- **States:** IDLE, GRANT, GAP.
- **Registers:**
  - 3-bit state.
  - 3-bit `ptr`: highest-priority index.
  - 3-bit `gnt_idx`.
  - `hold_cnt`, width `$clog2(HOLD_MAX+1)`.
  - `timeout` flag.
- **Outputs:** all outputs are registered or decoded from registers. There is no combinational path from `req` to any output.
- **Arbitration** is evaluated in IDLE and in GAP:
  - Winner is the first k with `req[k]` high, searching `ptr`, `ptr+1`, … `ptr+7`, all mod 8.
  - If there is a winner: next state is GRANT, `gnt_idx` ← winner, `hold_cnt` ← 1.
  - If there is no winner: next state is IDLE and `gnt_idx` holds its value.
- **GRANT:** `gnt_valid` = 1.
  - **Release:** if `req[gnt_idx]` = 0, go to GAP with `timeout` ← 0.
  - **Timeout:** else if `hold_cnt == HOLD_MAX`, go to GAP with `timeout` ← 1.
  - **Otherwise:** `hold_cnt` increments and the state stays GRANT.
  - Release has priority over timeout when both hold in the same cycle.
  - Requests from other indices are ignored while in GRANT.
- **On every GRANT→GAP transition:** `ptr` ← `gnt_idx + 1` (mod 8; index 7 wraps to 0). The last grantee therefore becomes lowest priority.
- **GAP:** `gnt_valid` = 0 and `gnt` = 0, giving exactly one dead cycle between grants. `timeout` is visible only during this cycle. Arbitration uses the already-updated `ptr`.
- **IDLE:** `gnt_valid` = 0 and `timeout` = 0.
- **Reset** (`rst_n` low at a clock edge), from any state including mid-grant:
  - state ← IDLE, `ptr` ← 0, `gnt_idx` ← 0, `hold_cnt` ← 0, `timeout` ← 0.
  - Outputs after reset: `gnt` = 8'h00, `gnt_idx` = 0, `gnt_valid` = 0, `timeout` = 0.
  - Reset overrides all other transitions.

## Timing

- **Grant latency:** `req` high in cycle n while in IDLE gives `gnt` high in cycle n+1.
- **Release latency:** `req[gnt_idx]` low in cycle m while in GRANT gives `gnt` low in cycle m+1 (GAP). The grantee must tolerate `gnt` high during cycle m.
- **Back-to-back:** the next grant is visible in cycle m+2 if any request is pending in cycle m+1.
- **Hold limit:** one grant lasts at most `HOLD_MAX` cycles (`hold_cnt` runs 1..`HOLD_MAX`).
- **HOLD_MAX = 1:** every grant lasts 1 cycle, and `timeout` pulses if `req` is still high.
- **Idle throughput:** with all 8 requesters continuously active, each receives `HOLD_MAX` cycles out of every 8·(`HOLD_MAX`+1).

## Test plan

1. **Reset:** hold `rst_n` low 3 cycles with `req` = 8'hFF → `gnt` = 8'h00, `gnt_idx` = 0, `gnt_valid` = 0, `timeout` = 0 throughout. The first grant after release is index 0, one cycle after `rst_n` goes high.
2. **Single requester:** `HOLD_MAX` = 15, `req[3]` high for cycles 1–5 → `gnt` = 8'h08 in cycles 2–6, 8'h00 from cycle 7, `timeout` never asserts.
3. **Full rotation:** `req` = 8'hFF, each grantee drops its `req` after its 2nd grant cycle and re-raises it in the next cycle → grant order 0,1,2,3,4,5,6,7,0. Each grant is 2 cycles long with exactly one zero-`gnt` cycle between grants.
4. **Timeout:** `HOLD_MAX` = 4, `req[5]` stuck high, other requests 0 → `gnt` = 8'h20 for exactly 4 cycles, then a GAP cycle with `timeout` = 1, then `gnt` = 8'h20 again. The pattern repeats with period 5.
5. **Wrap and fairness:**
   - After a grant to 6 is released, apply `req` = 8'h41 → next grant is index 0 (`ptr` = 7, search wraps), then 6.
   - Release and timeout in the same cycle → `timeout` stays 0.
6. **Reset mid-grant:** during cycle 3 of a grant to index 2, pull `rst_n` low for one cycle → `gnt` = 8'h00 and `ptr` = 0 next cycle. With `req` = 8'h06, the next grant goes to index 1.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: 8-way round-robin arbiter for the shared ALU datapath.
// Outputs are decoded from registers only. Each grant has a hold limit,
// and consecutive grants are separated by one dead GAP cycle.
module alu_req_arbiter #(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int            CW      = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_GAP   = 3'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [2:0]    ptr_r, ptr_nxt_s;
  logic [2:0]    gnt_idx_r, gnt_idx_nxt_s;
  logic [CW-1:0] hold_cnt_r, hold_cnt_nxt_s;
  logic          timeout_r, timeout_nxt_s;
  logic          win_found_s;
  logic [2:0]    win_idx_s;

  // Round-robin search: the first set request starting at p and wrapping mod 8.
  // Result bit 3 is the found flag, and bits 2:0 are the winning index.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic       found;
    logic [2:0] w;
    logic [2:0] k;
    found = 1'b0;
    w     = 3'd0;
    for (int i = 0; i < 8; i++) begin
      k = p + 3'(i);
      if (!found && r[k]) begin
        found = 1'b1;
        w     = k;
      end else begin
        found = found;
      end
    end
    return {found, w};
  endfunction

  // Winner of the current request vector against the priority pointer
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = 3'd0;
    {win_found_s, win_idx_s} = rr_pick(req, ptr_r);
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and next-datapath logic: arbitration, hold limit, and release
  always_comb begin
    state_nxt_s    = state_r;
    ptr_nxt_s      = ptr_r;
    gnt_idx_nxt_s  = gnt_idx_r;
    hold_cnt_nxt_s = hold_cnt_r;
    timeout_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_GAP: begin
        if (win_found_s) begin
          state_nxt_s    = ST_GRANT;
          gnt_idx_nxt_s  = win_idx_s;
          hold_cnt_nxt_s = CNT_ONE;
        end else begin
          state_nxt_s    = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // A release takes priority over the timeout, so timeout_nxt_s stays 0 in that case.
        if (!req[gnt_idx_r]) begin
          state_nxt_s   = ST_GAP;
          ptr_nxt_s     = gnt_idx_r + 3'd1;
        end else if (hold_cnt_r == CNT_MAX) begin
          state_nxt_s   = ST_GAP;
          ptr_nxt_s     = gnt_idx_r + 3'd1;
          timeout_nxt_s = 1'b1;
        end else begin
          hold_cnt_nxt_s = hold_cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Datapath registers: priority pointer, grantee, hold counter, and timeout flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r      <= 3'd0;
      gnt_idx_r  <= 3'd0;
      hold_cnt_r <= '0;
      timeout_r  <= 1'b0;
    end else begin
      ptr_r      <= ptr_nxt_s;
      gnt_idx_r  <= gnt_idx_nxt_s;
      hold_cnt_r <= hold_cnt_nxt_s;
      timeout_r  <= timeout_nxt_s;
    end
  end

  // Output decode from registered state only; there is no path from req
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = 8'h00;
    gnt_idx   = gnt_idx_r;
    timeout   = timeout_r;
    if (state_r == ST_GRANT) begin
      gnt_valid = 1'b1;
      gnt       = 8'h01 << gnt_idx_r;
    end else begin
      gnt_valid = 1'b0;
      gnt       = 8'h00;
    end
  end

endmodule
